// File: rtl/sparc_ifu_thrsched.sv
// Round-robin thread scheduler for the IFU: issues one-hot schedule pulses to
// eligible threads and preempts the running thread with switch_out once its quantum is spent.
module sparc_ifu_thrsched #(
  parameter int NTHR    = 4,
  parameter int QUANTUM = 8,
  parameter int CW      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTHR*5-1:0] thr_state,
  input  logic              fcl_hold,
  output logic [NTHR-1:0]   schedule,
  output logic              switch_out,
  output logic [NTHR-1:0]   cur_thr,
  output logic              cur_vld,
  output logic              illegal_st
);

  localparam int IW = (NTHR > 1) ? $clog2(NTHR) : 1;
  localparam logic [CW-1:0] QCNT = CW'(QUANTUM);

  localparam logic [4:0] ST_IDLE     = 5'b00000;
  localparam logic [4:0] ST_HALT     = 5'b00010;
  localparam logic [4:0] ST_RDY      = 5'b11001;
  localparam logic [4:0] ST_RUN      = 5'b00101;
  localparam logic [4:0] ST_WAIT     = 5'b00001;
  localparam logic [4:0] ST_SPEC_RDY = 5'b10011;
  localparam logic [4:0] ST_SPEC_RUN = 5'b00111;

  typedef enum logic [1:0] {S_IDLE, S_SCHED, S_RUN, S_SWOUT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   rr_ptr;

  logic [NTHR-1:0] elig_rdy;
  logic [NTHR-1:0] elig_spec;
  logic [NTHR-1:0] eligible;
  logic [NTHR-1:0] running;
  logic [NTHR-1:0] legal;
  logic [IW-1:0]   pick;
  logic            any_elig;
  logic            cur_run;
  logic            other_elig;

  // First requester found searching upward from ptr+1, wrapping at NTHR.
  function automatic logic [IW-1:0] rr_pick(input logic [NTHR-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] r;
    logic [IW-1:0] idx;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= NTHR; k++) begin
      idx = IW'((int'(ptr) + k) % NTHR);
      if (!found && req[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    elig_rdy  = '0;
    elig_spec = '0;
    running   = '0;
    legal     = '0;
    for (int i = 0; i < NTHR; i++) begin
      elig_rdy[i]  = (thr_state[5*i +: 5] == ST_RDY);
      elig_spec[i] = (thr_state[5*i +: 5] == ST_SPEC_RDY);
      running[i]   = (thr_state[5*i +: 5] == ST_RUN) ||
                     (thr_state[5*i +: 5] == ST_SPEC_RUN);
      legal[i]     = thr_state[5*i +: 5] inside {ST_IDLE, ST_HALT, ST_RDY, ST_RUN,
                                                 ST_WAIT, ST_SPEC_RDY, ST_SPEC_RUN};
    end
    eligible   = elig_rdy | elig_spec;
    any_elig   = |eligible;
    // Ready threads always win over speculative-ready ones, regardless of rr order.
    pick       = rr_pick((|elig_rdy) ? elig_rdy : elig_spec, rr_ptr);
    cur_run    = |(running & cur_thr);
    other_elig = |(eligible & ~cur_thr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr_ptr     <= IW'(NTHR - 1);
      schedule   <= '0;
      switch_out <= 1'b0;
      cur_thr    <= '0;
      cur_vld    <= 1'b0;
      illegal_st <= 1'b0;
    end else begin
      illegal_st <= |(~legal);
      schedule   <= '0;
      switch_out <= 1'b0;
      case (state)
        S_IDLE: begin
          cur_vld <= 1'b0;
          cur_thr <= '0;
          if (any_elig && !fcl_hold) begin
            schedule <= NTHR'(1) << pick;
            cur_thr  <= NTHR'(1) << pick;
            cur_vld  <= 1'b1;
            rr_ptr   <= pick;
            state    <= S_SCHED;
          end
        end
        S_SCHED: begin
          // While the pulse is still out the thread FSM has not moved yet.
          if (schedule == '0) begin
            if (cur_run) begin
              state <= S_RUN;
              cnt   <= CW'(1);
            end else begin
              state   <= S_IDLE;
              cur_vld <= 1'b0;
              cur_thr <= '0;
            end
          end
        end
        S_RUN: begin
          if (cnt < QCNT) cnt <= cnt + CW'(1);
          if (!cur_run) begin
            state   <= S_IDLE;
            cur_vld <= 1'b0;
            cur_thr <= '0;
          end else if (cnt >= QCNT && other_elig && !fcl_hold) begin
            switch_out <= 1'b1;
            state      <= S_SWOUT;
          end
        end
        S_SWOUT: begin
          if (!cur_run) begin
            state   <= S_IDLE;
            cur_vld <= 1'b0;
            cur_thr <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Directed bench for sparc_ifu_thrsched; a small thread-FSM responder reacts
// to schedule/switch_out, with per-test overrides for stalls and illegal states.
module tb_sparc_ifu_thrsched;

  localparam int NTHR    = 4;
  localparam int QUANTUM = 8;
  localparam int CW      = 4;

  localparam logic [4:0] IDLE     = 5'b00000;
  localparam logic [4:0] RDY      = 5'b11001;
  localparam logic [4:0] RUN      = 5'b00101;
  localparam logic [4:0] WAITS    = 5'b00001;
  localparam logic [4:0] SPEC_RDY = 5'b10011;
  localparam logic [4:0] SPEC_RUN = 5'b00111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NTHR*5-1:0] thr_state;
  logic              fcl_hold;
  logic [NTHR-1:0]   schedule;
  logic              switch_out;
  logic [NTHR-1:0]   cur_thr;
  logic              cur_vld;
  logic              illegal_st;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   env_en = 1'b1;
  logic [4:0] ts [NTHR];

  always #5 clk = ~clk;

  sparc_ifu_thrsched #(.NTHR(NTHR), .QUANTUM(QUANTUM), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .thr_state  (thr_state),
    .fcl_hold   (fcl_hold),
    .schedule   (schedule),
    .switch_out (switch_out),
    .cur_thr    (cur_thr),
    .cur_vld    (cur_vld),
    .illegal_st (illegal_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NTHR; i++) thr_state[5*i +: 5] = ts[i];
  endtask

  // One clock; the responder moves thread states just after the edge.
  task automatic cyc(input int n);
    logic [NTHR-1:0] s;
    logic            w;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s = schedule;
      w = switch_out;
      @(posedge clk);
      #1;
      if (env_en) begin
        for (int i = 0; i < NTHR; i++) begin
          if (s[i] && ts[i] == RDY)           ts[i] = RUN;
          else if (s[i] && ts[i] == SPEC_RDY) ts[i] = SPEC_RUN;
          if (w && (ts[i] == RUN || ts[i] == SPEC_RUN)) ts[i] = RDY;
        end
        drive();
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sched"}, 32'(schedule), 32'h0);
    check({tag, "_sw"},    32'(switch_out), 32'h0);
    check({tag, "_cur"},   32'(cur_thr), 32'h0);
    check({tag, "_vld"},   32'(cur_vld), 32'h0);
    check({tag, "_ill"},   32'(illegal_st), 32'h0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    fcl_hold = 1'b0;
    env_en   = 1'b1;
    for (int i = 0; i < NTHR; i++) ts[i] = IDLE;
    drive();
    cyc(2);
    check_zero("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1 + 2: first schedule after reset, then quantum preemption.
    do_reset();
    ts[0] = RDY; drive();
    rst_n = 1'b1;
    cyc(1);
    check("t1_sched", 32'(schedule), 32'h1);
    check("t1_cur",   32'(cur_thr), 32'h1);
    check("t1_vld",   32'(cur_vld), 32'h1);
    cyc(1);
    check("t1_pulse_end", 32'(schedule), 32'h0);
    cyc(1);
    ts[2] = RDY; drive();
    for (int k = 4; k <= 10; k++) begin
      cyc(1);
      check("t2_no_sw_early", 32'(switch_out), 32'h0);
    end
    cyc(1);
    check("t2_sw",       32'(switch_out), 32'h1);
    check("t2_sw_sched", 32'(schedule), 32'h0);
    cyc(1);
    check("t2_sw_once",  32'(switch_out), 32'h0);
    check("t2_vld_swout", 32'(cur_vld), 32'h1);
    cyc(1);
    check("t2_idle_vld", 32'(cur_vld), 32'h0);
    check("t2_idle_cur", 32'(cur_thr), 32'h0);
    cyc(1);
    check("t2_next_sched", 32'(schedule), 32'h4);
    check("t2_next_cur",   32'(cur_thr), 32'h4);

    // Test 3: RDY beats SPEC_RDY even when rr order favours the latter.
    do_reset();
    ts[0] = RDY; ts[2] = RDY; drive();
    rst_n = 1'b1;
    cyc(1);
    check("t3_rr_first", 32'(schedule), 32'h1);
    cyc(2);
    ts[0] = WAITS; ts[1] = SPEC_RDY; ts[2] = IDLE; ts[3] = RDY; drive();
    cyc(1);
    check("t3_leave_vld", 32'(cur_vld), 32'h0);
    cyc(1);
    check("t3_sched", 32'(schedule), 32'h8);
    check("t3_cur",   32'(cur_thr), 32'h8);

    // Test 4: stall races schedule; then fcl_hold blocks a new schedule in idle.
    do_reset();
    ts[0] = RDY; drive();
    rst_n = 1'b1;
    cyc(1);
    check("t4_sched", 32'(schedule), 32'h1);
    env_en = 1'b0;
    cyc(1);
    ts[0] = WAITS; drive();
    check("t4_vld_sched", 32'(cur_vld), 32'h1);
    cyc(1);
    check("t4_back_idle", 32'(cur_vld), 32'h0);
    check("t4_cur_clr",   32'(cur_thr), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("t4_no_sw",    32'(switch_out), 32'h0);
      check("t4_no_sched", 32'(schedule), 32'h0);
    end
    env_en = 1'b1;
    fcl_hold = 1'b1; ts[1] = RDY; drive();
    cyc(2);
    check("t4_hold_sched", 32'(schedule), 32'h0);
    fcl_hold = 1'b0;
    cyc(1);
    check("t4_release_sched", 32'(schedule), 32'h2);

    // Test 5: quantum expired, nobody else eligible, then hold delays switch_out.
    do_reset();
    ts[0] = RDY; drive();
    rst_n = 1'b1;
    cyc(3);
    for (int k = 4; k <= 12; k++) begin
      cyc(1);
      check("t5_alone_no_sw", 32'(switch_out), 32'h0);
    end
    fcl_hold = 1'b1; ts[1] = RDY; drive();
    for (int k = 13; k <= 17; k++) begin
      cyc(1);
      check("t5_hold_no_sw",    32'(switch_out), 32'h0);
      check("t5_hold_no_sched", 32'(schedule), 32'h0);
    end
    fcl_hold = 1'b0;
    cyc(1);
    check("t5_sw_after_hold", 32'(switch_out), 32'h1);
    // Test 6b: reset while the switch_out pulse is out.
    rst_n = 1'b0;
    cyc(1);
    check_zero("t6_rst_swout");

    // Test 6a: illegal encodings.
    do_reset();
    ts[0] = 5'b11111; drive();
    rst_n = 1'b1;
    cyc(1);
    check("t6_illegal",     32'(illegal_st), 32'h1);
    check("t6_ill_nosched", 32'(schedule), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("t6_never_sched", 32'(schedule), 32'h0);
      check("t6_never_vld",   32'(cur_vld), 32'h0);
    end
    ts[0] = IDLE; ts[2] = 5'b01001; drive();
    cyc(1);
    check("t6_illegal_t2", 32'(illegal_st), 32'h1);
    ts[2] = IDLE; drive();
    cyc(1);
    check("t6_legal_again", 32'(illegal_st), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
